// File: rtl/vector_stack_machine_pkg.sv
// Shared definitions for the vector stack machine.
//   - opcode and error-code constants
//   - FSM state enum
//   - reduce_fn: brings a wide signed intermediate back to an n-bit result.
// Build option: define VECTOR_STACK_MACHINE_SATURATE_EN to clamp results to the
// signed n-bit range; leave it undefined for two's-complement wrap-around.
package vector_stack_machine_pkg;

    localparam logic [2:0] OP_X   = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;

    localparam logic [2:0] ERR_OK         = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW  = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW   = 3'd2;
    localparam logic [2:0] ERR_BAD_OPCODE = 3'd3;
    localparam logic [2:0] ERR_DEPTH      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Reduce a signed 64-bit intermediate to n bits (n <= 32); the caller
    // truncates the return value to n bits.
    function automatic longint reduce_fn(input longint v, input int n);
`ifdef VECTOR_STACK_MACHINE_SATURATE_EN
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (n - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - n)) >>> (64 - n);
`endif
    endfunction

endpackage

// File: rtl/vector_stack_machine_if.sv
// Token-queue bus between the vector stack machine (master) and the output
// queue (slave).
//   output_queue_index  : token index requested by the machine
//   output_queue_get    : one-cycle read request
//   output_queue_length : program length (sampled by the machine on start)
//   output_queue_data_out: token; bit N set = operator with opcode in [N-1:0]
//   output_queue_ready  : one-cycle pulse, data_out valid
// Handshake: the machine raises get for exactly one cycle with a stable index,
// then waits; the queue answers some cycles later (>=1) with a single ready
// pulse carrying the token. Ready pulses with no outstanding request are
// ignored. N and SIZE must match the machine's N and OUTPUT_QUEUE_SIZE.
interface vector_stack_machine_if #(
    parameter int N    = 19,
    parameter int SIZE = 64
);
    logic [$clog2(SIZE)-1:0]   output_queue_index;
    logic                      output_queue_get;
    logic [$clog2(SIZE+1)-1:0] output_queue_length;
    logic [N:0]                output_queue_data_out;
    logic                      output_queue_ready;

    modport master (
        output output_queue_index, output_queue_get,
        input  output_queue_length, output_queue_data_out, output_queue_ready
    );

    modport slave (
        input  output_queue_index, output_queue_get,
        output output_queue_length, output_queue_data_out, output_queue_ready
    );
endinterface

// File: rtl/vsm_lane_alu.sv
// Per-lane combinational ALU of the vector stack machine.
//   op     : opcode (X, SUB, ADD, MUL, NEG)
//   a      : second-from-top stack entry
//   b      : top stack entry
//   x      : this lane's x value
//   result : value written back to the stack
// Results are reduced with reduce_fn (wrap or saturate depending on
// VECTOR_STACK_MACHINE_SATURATE_EN).
module vsm_lane_alu
    import vector_stack_machine_pkg::*;
#(
    parameter int N    = 19,
    parameter int FRAC = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] x,
    output logic [N-1:0] result
);
    longint sa;
    longint sb;
    longint prod;

    always_comb begin
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        // Full 2N-bit product; 64 bits hold it for any N up to 32.
        prod = sa * sb;
        case (op)
            OP_X:    result = x;
            OP_SUB:  result = N'(reduce_fn(sa - sb, N));
            OP_ADD:  result = N'(reduce_fn(sa + sb, N));
            OP_MUL:  result = N'(reduce_fn(prod >>> FRAC, N));
            OP_NEG:  result = N'(reduce_fn(-sb, N));
            default: result = b;
        endcase
    end
endmodule

// File: rtl/vector_stack_machine.sv
// Multi-lane RPN stack machine. Fetches tokens one at a time from the output
// queue and evaluates the program for LANES x values in lockstep
// (x_i = x_input + i*x_step). Each lane owns a STACK_DEPTH-entry stack; one
// shared depth counter means stack errors hit every lane identically.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start/ready  : start pulse accepted while ready (idle, results valid)
//   x_input/x_step: lane-0 x and lane-to-lane increment
//   y_output     : lane i result at [i*N +: N]
//   error_code   : 0 ok, 1 underflow, 2 overflow, 3 bad opcode, 4 final depth
//   oq           : token-queue bus (master side)
//   dbg_state    : current FSM state
// Build option: VECTOR_STACK_MACHINE_SATURATE_EN selects saturating arithmetic.
module vector_stack_machine
    import vector_stack_machine_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 11,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    parameter int LANES                 = 4,
    parameter int STACK_DEPTH           = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    output logic                                                   ready,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]    x_input,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]    x_step,
    output logic [LANES*(INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH)-1:0] y_output,
    output logic [2:0]                                             error_code,
    vector_stack_machine_if.master                                 oq,
    output state_t                                                 dbg_state
);
    localparam int N  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int IW = $clog2(OUTPUT_QUEUE_SIZE);
    localparam int LW = $clog2(OUTPUT_QUEUE_SIZE + 1);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int SW = $clog2(STACK_DEPTH);

    state_t         state_q, state_d;
    logic [IW-1:0]  tok_cnt_q, tok_cnt_d;
    logic [LW-1:0]  len_q, len_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [N:0]     tok_q, tok_d;
    logic [2:0]     err_q, err_d;
    logic [N-1:0]   y_q [LANES];
    logic [N-1:0]   y_d [LANES];
    logic [N-1:0]   lane_x_q [LANES];
    logic [N-1:0]   lane_x_d [LANES];
    logic [N-1:0]   stack_q [LANES][STACK_DEPTH];
    logic [N-1:0]   stack_d [LANES][STACK_DEPTH];
    logic [N-1:0]   alu_res [LANES];

    logic [SW-1:0]  top_idx, sec_idx, push_idx;
    logic           last_tok;
    logic           stack_full;
    logic [2:0]     exec_err;

    // Index selects are clamped to 0 when the stack is too shallow; those
    // cases raise an error and never write, so the clamped read is harmless.
    always_comb begin
        top_idx  = (depth_q != '0) ? SW'(depth_q - DW'(1)) : '0;
        sec_idx  = (depth_q >= DW'(2)) ? SW'(depth_q - DW'(2)) : '0;
        push_idx = (depth_q < DW'(STACK_DEPTH)) ? SW'(depth_q) : '0;
    end

    assign stack_full = (depth_q == DW'(STACK_DEPTH));
    assign last_tok   = ((LW'(tok_cnt_q) + LW'(1)) == len_q);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vsm_lane_alu #(.N(N), .FRAC(FRACTIONAL_PART_WIDTH)) u_alu (
            .op     (tok_q[2:0]),
            .a      (stack_q[l][sec_idx]),
            .b      (stack_q[l][top_idx]),
            .x      (lane_x_q[l]),
            .result (alu_res[l])
        );
        assign y_output[l*N +: N] = y_q[l];
    end

    always_comb begin
        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        len_d     = len_q;
        depth_d   = depth_q;
        tok_d     = tok_q;
        err_d     = err_q;
        y_d       = y_q;
        lane_x_d  = lane_x_q;
        stack_d   = stack_q;
        exec_err  = ERR_OK;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d     = ERR_OK;
                    depth_d   = '0;
                    tok_cnt_d = '0;
                    len_d     = oq.output_queue_length;
                    for (int l = 0; l < LANES; l++) begin
                        lane_x_d[l] = N'(reduce_fn(longint'($signed(x_input))
                                      + longint'(l) * longint'($signed(x_step)), N));
                    end
                    // An empty program goes straight to the depth check.
                    state_d = (oq.output_queue_length == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (oq.output_queue_ready) begin
                    tok_d   = oq.output_queue_data_out;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!tok_q[N]) begin
                    if (stack_full) begin
                        exec_err = ERR_OVERFLOW;
                    end else begin
                        for (int l = 0; l < LANES; l++) stack_d[l][push_idx] = tok_q[N-1:0];
                        depth_d = depth_q + DW'(1);
                    end
                end else if (tok_q[N-1:0] > N'(OP_NEG)) begin
                    exec_err = ERR_BAD_OPCODE;
                end else begin
                    case (tok_q[2:0])
                        OP_X: begin
                            if (stack_full) begin
                                exec_err = ERR_OVERFLOW;
                            end else begin
                                for (int l = 0; l < LANES; l++) stack_d[l][push_idx] = alu_res[l];
                                depth_d = depth_q + DW'(1);
                            end
                        end
                        OP_NEG: begin
                            if (depth_q == '0) begin
                                exec_err = ERR_UNDERFLOW;
                            end else begin
                                for (int l = 0; l < LANES; l++) stack_d[l][top_idx] = alu_res[l];
                            end
                        end
                        OP_SUB, OP_ADD, OP_MUL: begin
                            if (depth_q < DW'(2)) begin
                                exec_err = ERR_UNDERFLOW;
                            end else begin
                                for (int l = 0; l < LANES; l++) stack_d[l][sec_idx] = alu_res[l];
                                depth_d = depth_q - DW'(1);
                            end
                        end
                        default: exec_err = ERR_BAD_OPCODE;
                    endcase
                end

                if (exec_err != ERR_OK) begin
                    err_d   = exec_err;
                    state_d = ST_IDLE;
                end else if (last_tok) begin
                    state_d = ST_DONE;
                end else begin
                    tok_cnt_d = tok_cnt_q + IW'(1);
                    state_d   = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (depth_q != DW'(1)) begin
                    err_d = ERR_DEPTH;
                end else begin
                    for (int l = 0; l < LANES; l++) y_d[l] = stack_q[l][0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tok_cnt_q <= '0;
            len_q     <= '0;
            depth_q   <= '0;
            tok_q     <= '0;
            err_q     <= ERR_OK;
            for (int l = 0; l < LANES; l++) begin
                y_q[l]      <= '0;
                lane_x_q[l] <= '0;
                for (int d = 0; d < STACK_DEPTH; d++) stack_q[l][d] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tok_cnt_q <= tok_cnt_d;
            len_q     <= len_d;
            depth_q   <= depth_d;
            tok_q     <= tok_d;
            err_q     <= err_d;
            y_q       <= y_d;
            lane_x_q  <= lane_x_d;
            stack_q   <= stack_d;
        end
    end

    // ready/get are decoded from the state register only, so they are glitch
    // free and drop to their reset values as soon as rst_n falls.
    assign ready                 = (state_q == ST_IDLE);
    assign oq.output_queue_get   = (state_q == ST_FETCH);
    assign oq.output_queue_index = tok_cnt_q;
    assign error_code            = err_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_vector_stack_machine.sv
// Self-checking bench for vector_stack_machine: N=19 (11.8), LANES=4,
// STACK_DEPTH=4, token queue answering 10 cycles after each request.
module tb_vector_stack_machine;
    import vector_stack_machine_pkg::*;

    localparam int INT_W = 11;
    localparam int FRAC_W = 8;
    localparam int N = INT_W + FRAC_W;
    localparam int LANES = 4;
    localparam int SD = 4;
    localparam int QSIZE = 64;
    localparam int LAT = 10;
    localparam int IW = $clog2(QSIZE);
    localparam int LW = $clog2(QSIZE + 1);

    // ---------------- clock / reset / signals ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ready;
    logic [N-1:0]     x_input = '0;
    logic [N-1:0]     x_step = '0;
    logic [LANES*N-1:0] y_output;
    logic [2:0]       error_code;
    state_t           dbg_state;

    logic [LW-1:0]    q_len = '0;
    logic             resp_ready = 1'b0;
    logic             stray_ready = 1'b0;
    logic [N:0]       resp_data = '0;
    logic [N:0]       stray_data = '0;
    logic [N:0]       prog [QSIZE];
    int               fetch_log[$];

    initial forever #5 clk = ~clk;

    vector_stack_machine_if #(.N(N), .SIZE(QSIZE)) oq_if ();
    assign oq_if.output_queue_length   = q_len;
    assign oq_if.output_queue_ready    = resp_ready | stray_ready;
    assign oq_if.output_queue_data_out = resp_ready ? resp_data : stray_data;

    vector_stack_machine #(
        .INTEGER_PART_WIDTH(INT_W), .FRACTIONAL_PART_WIDTH(FRAC_W),
        .OUTPUT_QUEUE_SIZE(QSIZE), .LANES(LANES), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .x_input(x_input), .x_step(x_step), .y_output(y_output),
        .error_code(error_code), .oq(oq_if), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- token queue responder ----------------
    int resp_idx;
    bit resp_alive;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && oq_if.output_queue_get) begin
                resp_idx   = int'(oq_if.output_queue_index);
                resp_alive = 1'b1;
                fetch_log.push_back(resp_idx);
                for (int i = 0; i < LAT - 1; i++) begin
                    @(negedge clk);
                    if (!rst_n) resp_alive = 1'b0;
                end
                if (resp_alive) begin
                    resp_data  = prog[resp_idx];
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    longint     model_y [LANES];
    logic [2:0] model_err;

    function automatic logic [N:0] lit(input int v);
        return {1'b0, N'(v)};
    endfunction

    function automatic logic [N:0] op(input int c);
        return {1'b1, N'(c)};
    endfunction

    function automatic longint m_reduce(input longint v);
        longint full;
        longint half;
        longint m;
        full = longint'(1) << N;
        half = longint'(1) << (N - 1);
`ifdef VECTOR_STACK_MACHINE_SATURATE_EN
        if (v > half - 1) return half - 1;
        if (v < -half) return -half;
        return v;
`else
        m = v % full;
        if (m < 0) m = m + full;
        if (m >= half) m = m - full;
        return m;
`endif
    endfunction

    // Evaluates prog[0..len_i-1] lane by lane with a queue as the stack.
    task automatic model_run(input int len_i, input logic [N-1:0] xin, input logic [N-1:0] xs);
        longint res [LANES];
        logic [2:0] e;
        e = 3'd0;
        for (int l = 0; l < LANES; l++) begin
            longint s[$];
            longint x, a, b;
            logic signed [N-1:0] v;
            int opc;
            s.delete();
            e = 3'd0;
            x = m_reduce(longint'($signed(xin)) + longint'(l) * longint'($signed(xs)));
            for (int i = 0; i < len_i && e == 3'd0; i++) begin
                if (!prog[i][N]) begin
                    if (s.size() == SD) e = 3'd2;
                    else begin
                        v = prog[i][N-1:0];
                        s.push_back(longint'(v));
                    end
                end else begin
                    opc = int'(prog[i][N-1:0]);
                    if (opc == 0) begin
                        if (s.size() == SD) e = 3'd2;
                        else s.push_back(x);
                    end else if (opc >= 1 && opc <= 3) begin
                        if (s.size() < 2) e = 3'd1;
                        else begin
                            b = s.pop_back();
                            a = s.pop_back();
                            if (opc == 1) s.push_back(m_reduce(a - b));
                            else if (opc == 2) s.push_back(m_reduce(a + b));
                            else s.push_back(m_reduce((a * b) >>> FRAC_W));
                        end
                    end else if (opc == 4) begin
                        if (s.size() < 1) e = 3'd1;
                        else s[s.size()-1] = m_reduce(-s[s.size()-1]);
                    end else begin
                        e = 3'd3;
                    end
                end
            end
            if (e == 3'd0 && s.size() != 1) e = 3'd4;
            res[l] = (e == 3'd0) ? s[0] : 0;
        end
        model_err = e;
        if (e == 3'd0) for (int l = 0; l < LANES; l++) model_y[l] = res[l];
    endtask

    // ---------------- driver tasks ----------------
    logic          st_ready, st_get;
    logic [IW-1:0] st_index;

    task automatic run_prog(input int len_i, input logic [N-1:0] xin, input logic [N-1:0] xs);
        int cnt;
        q_len   = LW'(len_i);
        x_input = xin;
        x_step  = xs;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        st_ready = ready;
        st_get   = oq_if.output_queue_get;
        st_index = oq_if.output_queue_index;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout ready=%b required 1 after %0d cycles", ready, cnt);
        end
        model_run(len_i, xin, xs);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (y_output !== '0) begin n_fail++; $display("FAIL reset_y got %h want 0", y_output); end
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", error_code); end
        n_checks++; if (oq_if.output_queue_get !== 1'b0) begin n_fail++; $display("FAIL reset_get got %b want 0", oq_if.output_queue_get); end
        n_checks++; if (oq_if.output_queue_index !== '0) begin n_fail++; $display("FAIL reset_index got %0d want 0", oq_if.output_queue_index); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
        rst_n = 1'b1;
        for (int l = 0; l < LANES; l++) model_y[l] = 0;
        @(negedge clk);
    endtask

    task automatic test_sub();
        prog[0] = lit(512); prog[1] = lit(1280); prog[2] = op(1);
        run_prog(3, N'(512), N'(256));
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready got %b want 0", st_ready); end
        n_checks++; if (st_get !== 1'b1) begin n_fail++; $display("FAIL start_get got %b want 1", st_get); end
        n_checks++; if (st_index !== '0) begin n_fail++; $display("FAIL start_index got %0d want 0", st_index); end
        for (int l = 0; l < LANES; l++) begin
            n_checks++;
            if (y_output[l*N +: N] !== 19'h7FD00) begin
                n_fail++; $display("FAIL sub_y lane %0d got %h want 7fd00", l, y_output[l*N +: N]);
            end
        end
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL sub_err got %0d want 0", error_code); end
    endtask

    task automatic test_mul_x();
        int exp_v [LANES];
        exp_v = '{1024, 2304, 4096, 6400};
        prog[0] = op(0); prog[1] = op(0); prog[2] = op(3);
        run_prog(3, N'(512), N'(256));
        for (int l = 0; l < LANES; l++) begin
            n_checks++;
            if (y_output[l*N +: N] !== N'(exp_v[l])) begin
                n_fail++; $display("FAIL mulx_y lane %0d got %0d want %0d", l, y_output[l*N +: N], exp_v[l]);
            end
        end
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL mulx_err got %0d want 0", error_code); end
    endtask

    // Each case must leave y_output at the squares from test_mul_x.
    task automatic test_errors();
        int exp_v [LANES];
        int lens [5];
        logic [2:0] exp_e [5];
        exp_v = '{1024, 2304, 4096, 6400};
        lens  = '{5, 1, 2, 1, 0};
        exp_e = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd4};
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: for (int i = 0; i < 5; i++) prog[i] = lit(256);
                1: prog[0] = op(1);
                2: begin prog[0] = lit(256); prog[1] = lit(256); end
                3: prog[0] = op(7);
                default: prog[0] = lit(256);
            endcase
            run_prog(lens[c], N'(512), N'(256));
            n_checks++;
            if (error_code !== exp_e[c]) begin
                n_fail++; $display("FAIL err_code case %0d got %0d want %0d", c, error_code, exp_e[c]);
            end
            n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL err_ready case %0d got %b want 1", c, ready); end
            for (int l = 0; l < LANES; l++) begin
                n_checks++;
                if (y_output[l*N +: N] !== N'(exp_v[l])) begin
                    n_fail++; $display("FAIL err_y_hold case %0d lane %0d got %0d want %0d", c, l, y_output[l*N +: N], exp_v[l]);
                end
            end
        end
    endtask

    task automatic test_mul_big();
        logic [N-1:0] exp_y;
`ifdef VECTOR_STACK_MACHINE_SATURATE_EN
        exp_y = 19'h3FFFF;
`else
        exp_y = 19'h24000;
`endif
        prog[0] = lit(256000); prog[1] = lit(256000); prog[2] = op(3);
        run_prog(3, N'(512), N'(256));
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL mulbig_err got %0d want 0", error_code); end
        for (int l = 0; l < LANES; l++) begin
            n_checks++;
            if (y_output[l*N +: N] !== exp_y) begin
                n_fail++; $display("FAIL mulbig_y lane %0d got %h want %h", l, y_output[l*N +: N], exp_y);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        prog[0] = lit(512); prog[1] = lit(1280); prog[2] = op(2);
        q_len = LW'(3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (dbg_state !== ST_WAIT && cnt < 100) begin @(negedge clk); cnt++; end
        n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rstmid_reach_wait got %0d want WAIT", dbg_state); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", ready); end
        n_checks++; if (oq_if.output_queue_get !== 1'b0) begin n_fail++; $display("FAIL rstmid_get got %b want 0", oq_if.output_queue_get); end
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL rstmid_err got %0d want 0", error_code); end
        n_checks++; if (y_output !== '0) begin n_fail++; $display("FAIL rstmid_y got %h want 0", y_output); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int l = 0; l < LANES; l++) model_y[l] = 0;
        repeat (LAT + 2) @(negedge clk);
        run_prog(3, N'(512), N'(256));
        n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL rstmid_after_err got %0d want 0", error_code); end
        for (int l = 0; l < LANES; l++) begin
            n_checks++;
            if (y_output[l*N +: N] !== N'(1792)) begin
                n_fail++; $display("FAIL rstmid_after_y lane %0d got %0d want 1792", l, y_output[l*N +: N]);
            end
        end
    endtask

    task automatic test_back_to_back_busy();
        int cnt;
        int len_i;
        prog[0] = lit(300); prog[1] = op(0); prog[2] = op(2);
        prog[3] = lit(-640); prog[4] = op(3); prog[5] = op(4);
        len_i = 6;
        q_len = LW'(len_i); x_input = N'(-700); x_step = N'(333);
        fetch_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        q_len = LW'(2);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 3000) begin
            start = ($urandom_range(0, 2) == 0);
            stray_data = {1'b1, N'($urandom_range(0, 7))};
            stray_ready = (dbg_state != ST_WAIT) && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0; stray_ready = 1'b0;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL busy_timeout ready=%b want 1", ready); end
        model_run(len_i, N'(-700), N'(333));
        n_checks++; if (error_code !== model_err) begin n_fail++; $display("FAIL busy_err got %0d want %0d", error_code, model_err); end
        for (int l = 0; l < LANES; l++) begin
            n_checks++;
            if (y_output[l*N +: N] !== N'(model_y[l])) begin
                n_fail++; $display("FAIL busy_y lane %0d got %h want %h", l, y_output[l*N +: N], N'(model_y[l]));
            end
        end
        n_checks++; if (fetch_log.size() != len_i) begin n_fail++; $display("FAIL busy_fetch_count got %0d want %0d", fetch_log.size(), len_i); end
        for (int i = 0; i < fetch_log.size() && i < len_i; i++) begin
            n_checks++;
            if (fetch_log[i] != i) begin n_fail++; $display("FAIL busy_fetch_order slot %0d got %0d want %0d", i, fetch_log[i], i); end
        end
    endtask

    task automatic test_random();
        int len_i, d, r, c;
        logic [N-1:0] xin, xs;
        for (int it = 0; it < 25; it++) begin
            len_i = $urandom_range(1, 10);
            d = 0;
            for (int i = 0; i < len_i; i++) begin
                r = $urandom_range(0, 99);
                if (r < 8) prog[i] = op($urandom_range(0, 7));
                else if (d < 2 || r < 45) begin
                    if ($urandom_range(0, 1) == 1) prog[i] = lit(int'($urandom_range(0, 8191)) - 4096);
                    else prog[i] = op(0);
                    d++;
                end else begin
                    c = $urandom_range(1, 4);
                    prog[i] = op(c);
                    if (c != 4) d--;
                end
            end
            xin = N'($urandom);
            xs  = N'($urandom_range(0, 4095));
            run_prog(len_i, xin, xs);
            n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready it %0d got %b want 1", it, ready); end
            n_checks++; if (error_code !== model_err) begin n_fail++; $display("FAIL rand_err it %0d got %0d want %0d", it, error_code, model_err); end
            for (int l = 0; l < LANES; l++) begin
                n_checks++;
                if (y_output[l*N +: N] !== N'(model_y[l])) begin
                    n_fail++; $display("FAIL rand_y it %0d lane %0d got %h want %h", it, l, y_output[l*N +: N], N'(model_y[l]));
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < QSIZE; i++) prog[i] = '0;
        test_reset();
        test_sub();
        test_mul_x();
        test_errors();
        test_mul_big();
        test_reset_mid();
        test_back_to_back_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
